// File: rtl/ram_arb_pkg.sv
// Shared types and default constants for the CPU/host RAM port arbiter.
package ram_arb_pkg;

  // Who owns the RAM port result in the cycle after a grant.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RD  = 2'd1,
    HOST_RD = 2'd2,
    WR      = 2'd3
  } owner_t;

  // Host denials tolerated before the host is forced onto the port.
  localparam int STARVE_LIMIT   = 4;
  // Back-to-back host grants before the CPU gets its turn.
  localparam int HOST_MAX_BURST = 8;

  // Bits needed to hold a saturating count in the range 0..max.
  function automatic int cnt_width(input int max);
    if (max < 1) begin
      return 1;
    end else begin
      return $clog2(max + 1);
    end
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the CPU, host and RAM port-a signals around the arbiter.
// master: the requesting environment (CPU, host, RAM data return).
// slave:  the arbiter itself.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);

  // CPU memory-stage side
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  // Loader / host side
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  // RAM port a
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  ram_addr, ram_wdata, ram_wren,
    output ram_q
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output ram_addr, ram_wdata, ram_wren,
    input  ram_q
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Holds at MAX instead of wrapping.
module sat_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count up to MAX and stop there; clear or reset returns to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r < W'(MAX))) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates a single RAM port between the CPU memory stage and a host
// loader. The grant is combinational from the live requests and two
// fairness counters; read data returns one cycle later and is steered by
// the registered owner FSM, not by whoever is granted now.
module ram_port_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int STARVE_LIMIT   = ram_arb_pkg::STARVE_LIMIT,
  parameter int HOST_MAX_BURST = ram_arb_pkg::HOST_MAX_BURST
) (
  input logic               clk,
  input logic               reset,
  ram_port_arbiter_if.slave bus
);

  import ram_arb_pkg::*;

  localparam int SW = cnt_width(STARVE_LIMIT);
  localparam int BW = cnt_width(HOST_MAX_BURST);

  logic [SW-1:0]     starve_cnt_s;
  logic [BW-1:0]     burst_cnt_s;
  logic              starve_hit_s;
  logic              burst_hit_s;
  logic              cpu_gnt_s;
  logic              host_gnt_s;
  logic              starve_inc_s;
  logic              starve_clr_s;
  logic              burst_inc_s;
  logic              burst_clr_s;
  logic [ADDR_W-1:0] gnt_addr_s;
  logic [DATA_W-1:0] gnt_wdata_s;
  logic              gnt_we_s;
  logic [ADDR_W-1:0] addr_hold_r;
  owner_t            owner_r;
  owner_t            owner_next_s;
  logic              cpu_rvalid_s;
  logic [DATA_W-1:0] cpu_rdata_s;
  logic              host_rvalid_s;
  logic [DATA_W-1:0] host_rdata_s;

  assign starve_hit_s = (starve_cnt_s == SW'(STARVE_LIMIT));
  assign burst_hit_s  = (burst_cnt_s  == BW'(HOST_MAX_BURST));

  // Priority grant: starved host, then CPU after a full host burst, then
  // CPU, then host. Nothing is granted while reset is held low.
  always_comb begin
    cpu_gnt_s  = 1'b0;
    host_gnt_s = 1'b0;
    if (!reset) begin
      cpu_gnt_s  = 1'b0;
      host_gnt_s = 1'b0;
    end else if (bus.host_req && starve_hit_s) begin
      host_gnt_s = 1'b1;
    end else if (bus.cpu_req && burst_hit_s) begin
      cpu_gnt_s = 1'b1;
    end else if (bus.cpu_req) begin
      cpu_gnt_s = 1'b1;
    end else if (bus.host_req) begin
      host_gnt_s = 1'b1;
    end else begin
      cpu_gnt_s  = 1'b0;
      host_gnt_s = 1'b0;
    end
  end

  // Steer the winner onto the RAM port; idle cycles keep the last address.
  always_comb begin
    gnt_addr_s  = addr_hold_r;
    gnt_wdata_s = {DATA_W{1'b0}};
    gnt_we_s    = 1'b0;
    if (cpu_gnt_s) begin
      gnt_addr_s  = bus.cpu_addr;
      gnt_wdata_s = bus.cpu_wdata;
      gnt_we_s    = bus.cpu_we;
    end else if (host_gnt_s) begin
      gnt_addr_s  = bus.host_addr;
      gnt_wdata_s = bus.host_wdata;
      gnt_we_s    = bus.host_we;
    end else begin
      gnt_addr_s  = addr_hold_r;
      gnt_wdata_s = {DATA_W{1'b0}};
      gnt_we_s    = 1'b0;
    end
  end

  // Remember the most recently granted address for idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_hold_r <= {ADDR_W{1'b0}};
    end else if (cpu_gnt_s || host_gnt_s) begin
      addr_hold_r <= gnt_addr_s;
    end else begin
      addr_hold_r <= addr_hold_r;
    end
  end

  // A denied host request ages; any grant or withdrawn request resets age.
  // Host grants extend the burst; any cycle without one ends it.
  always_comb begin
    starve_inc_s = bus.host_req && !host_gnt_s;
    starve_clr_s = !starve_inc_s;
    burst_inc_s  = host_gnt_s;
    burst_clr_s  = !host_gnt_s;
  end

  sat_counter #(
    .MAX (STARVE_LIMIT),
    .W   (SW)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (starve_inc_s),
    .clr   (starve_clr_s),
    .count (starve_cnt_s)
  );

  sat_counter #(
    .MAX (HOST_MAX_BURST),
    .W   (BW)
  ) u_burst_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (burst_inc_s),
    .clr   (burst_clr_s),
    .count (burst_cnt_s)
  );

  // Owner state register: records what this cycle's grant will return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_r <= IDLE;
    end else begin
      owner_r <= owner_next_s;
    end
  end

  // Owner next state from the grant, and read-return routing from the
  // current owner so a new grant never redirects a pending read.
  always_comb begin
    owner_next_s  = IDLE;
    cpu_rvalid_s  = 1'b0;
    cpu_rdata_s   = {DATA_W{1'b0}};
    host_rvalid_s = 1'b0;
    host_rdata_s  = {DATA_W{1'b0}};

    if (cpu_gnt_s) begin
      owner_next_s = bus.cpu_we ? WR : CPU_RD;
    end else if (host_gnt_s) begin
      owner_next_s = bus.host_we ? WR : HOST_RD;
    end else begin
      owner_next_s = IDLE;
    end

    case (owner_r)
      CPU_RD: begin
        cpu_rvalid_s = 1'b1;
        cpu_rdata_s  = bus.ram_q;
      end
      HOST_RD: begin
        host_rvalid_s = 1'b1;
        host_rdata_s  = bus.ram_q;
      end
      IDLE: begin
        cpu_rvalid_s  = 1'b0;
        host_rvalid_s = 1'b0;
      end
      WR: begin
        cpu_rvalid_s  = 1'b0;
        host_rvalid_s = 1'b0;
      end
      default: begin
        cpu_rvalid_s  = 1'b0;
        host_rvalid_s = 1'b0;
      end
    endcase
  end

  assign bus.ram_addr    = gnt_addr_s;
  assign bus.ram_wdata   = gnt_wdata_s;
  assign bus.ram_wren    = gnt_we_s;
  assign bus.cpu_stall   = bus.cpu_req && !cpu_gnt_s;
  assign bus.host_gnt    = host_gnt_s;
  assign bus.cpu_rvalid  = cpu_rvalid_s;
  assign bus.cpu_rdata   = cpu_rdata_s;
  assign bus.host_rvalid = host_rvalid_s;
  assign bus.host_rdata  = host_rdata_s;

endmodule
